// File: rtl/vec_byte_ram_if.sv
// Bus bundle for the byte-addressed vector RAM: enable, byte strobes,
// byte address, write data and registered read data.
interface vec_byte_ram_if #(
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter int ADDR_W = 24
) ();
  logic              en_i;
  logic [STRB_W-1:0] we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] d_i;
  logic [DATA_W-1:0] d_o;

  modport master (output en_i, output we_i, output addr_i, output d_i, input d_o);
  modport slave  (input en_i, input we_i, input addr_i, input d_i, output d_o);
endinterface

// File: rtl/vec_byte_ram.sv
// Single-port byte-addressed vector RAM. Any byte address opens an
// STRB_W-byte little-endian window; storage is split into STRB_W byte-wide
// banks (bank = byte address mod STRB_W) so an unaligned window touches
// every bank exactly once. Lanes that run past the last bank land one row
// higher, and the row index wraps so the window also wraps past the top.
module vec_byte_ram #(
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter int ADDR_W = 24,
  parameter int MEM_AW = 12
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vec_byte_ram_if.slave  bus
);
  localparam int LANE_AW = $clog2(STRB_W);
  localparam int ROW_W   = MEM_AW - LANE_AW;
  localparam int ROWS    = 1 << ROW_W;

  logic [LANE_AW-1:0] off;
  logic [ROW_W-1:0]   base_row;
  logic [LANE_AW-1:0] lane;
  logic [LANE_AW-1:0] bank_sel;
  logic [ROW_W-1:0]   row [STRB_W];
  logic [7:0]         wr_byte [STRB_W];
  logic [STRB_W-1:0]  wr_en;
  logic [DATA_W-1:0]  rd_bank;
  logic [DATA_W-1:0]  rd_word;

  assign off      = bus.addr_i[LANE_AW-1:0];
  assign base_row = bus.addr_i[MEM_AW-1:LANE_AW];

  // Address bits above the implemented storage are ignored.
  if (ADDR_W > MEM_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_i[ADDR_W-1:MEM_AW];
  end

  // Per bank: which lane lands here, which row it hits, and its write byte.
  always_comb begin
    lane = '0;
    for (int k = 0; k < STRB_W; k++) begin
      lane       = LANE_AW'(k) - off;
      // Banks below the start offset are reached only after wrapping the lane index,
      // so they belong to the next row.
      row[k]     = base_row + ROW_W'(LANE_AW'(k) < off);
      wr_en[k]   = bus.we_i[lane];
      wr_byte[k] = bus.d_i[int'(lane) * 8 +: 8];
    end
  end

  for (genvar k = 0; k < STRB_W; k++) begin : g_bank
    logic [7:0] mem [ROWS];

    // Byte write into this bank; memory is never cleared and is frozen during reset.
    always_ff @(posedge clk_i) begin
      if (!rst_i && bus.en_i && wr_en[k]) begin
        mem[row[k]] <= wr_byte[k];
      end
    end

    assign rd_bank[k*8 +: 8] = mem[row[k]];
  end

  // Rotate bank outputs back into lane order: lane i comes from bank (off + i).
  always_comb begin
    rd_word  = '0;
    bank_sel = '0;
    for (int i = 0; i < STRB_W; i++) begin
      bank_sel           = off + LANE_AW'(i);
      rd_word[i*8 +: 8]  = rd_bank[int'(bank_sel) * 8 +: 8];
    end
  end

  // Output register samples pre-write contents (read-first), holds when disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.d_o <= '0;
    end else if (bus.en_i) begin
      bus.d_o <= rd_word;
    end
  end
endmodule

// File: tb/tb_vec_byte_ram.sv
// Randomised bench for vec_byte_ram with a flat byte-array reference model
// and literal checks that pin the model to hand-computed words.
module tb_vec_byte_ram;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int ADDR_W = 24;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_byte_ram_if #(.DATA_W(DATA_W), .STRB_W(STRB_W), .ADDR_W(ADDR_W)) bus ();

  vec_byte_ram #(.DATA_W(DATA_W), .STRB_W(STRB_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0]  mm    [DEPTH];
  bit          known [DEPTH];
  logic [63:0] exp_d;
  logic [7:0]  exp_m;
  bit          chk_on = 1'b0;
  int          vectors = 0;
  int          errs = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req, input logic [7:0] m);
    logic [63:0] bm;
    bm = '0;
    for (int i = 0; i < 8; i++) if (m[i]) bm[i*8 +: 8] = 8'hFF;
    vectors++;
    if ((act & bm) !== (req & bm)) begin
      errs++;
      $display("FAIL %s: got %h, required %h (lanes %b)", name, act, req, m);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [63:0] v, input logic [7:0] m = 8'hFF);
    check({name, "_dut"}, bus.d_o, v, m);
    check({name, "_model"}, exp_d, v, m);
  endtask

  // One clock of stimulus; the model updates after the edge.
  task automatic cycle(input bit en, input logic [7:0] we, input logic [23:0] addr,
                       input logic [63:0] d);
    logic [63:0] r;
    logic [7:0]  m;
    int          a;
    @(negedge clk); #1;
    bus.en_i = en; bus.we_i = we; bus.addr_i = addr; bus.d_i = d;
    @(posedge clk); #1;
    if (!rst && en) begin
      for (int i = 0; i < 8; i++) begin
        a = (int'(addr[MEM_AW-1:0]) + i) % DEPTH;
        r[i*8 +: 8] = mm[a];
        m[i] = known[a];
      end
      exp_d = r;
      exp_m = m;
      for (int i = 0; i < 8; i++) begin
        if (we[i]) begin
          a = (int'(addr[MEM_AW-1:0]) + i) % DEPTH;
          mm[a] = d[i*8 +: 8];
          known[a] = 1'b1;
        end
      end
    end
  endtask

  // Reset between edges, an attempted write while held, then release.
  task automatic async_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    exp_d = '0;
    exp_m = 8'hFF;
    lit("rst_clear", 64'h0);
    cycle(1'b1, 8'hFF, 24'h000000, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.en_i = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  // Every cycle, compare the output against the model where lanes are defined.
  always @(negedge clk) begin
    if (chk_on && exp_m != 8'h00) check("d_o", bus.d_o, exp_d, exp_m);
  end

  initial begin
    logic [23:0] addr;
    int          sel;
    bus.en_i = 1'b0; bus.we_i = '0; bus.addr_i = '0; bus.d_i = '0;
    rst = 1'b1;
    exp_d = '0;
    exp_m = 8'hFF;
    #3;
    lit("reset_d_o", 64'h0);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Aligned full write then read
    cycle(1'b1, 8'hFF, 24'h000000, 64'h1122334455667788);
    cycle(1'b1, 8'h00, 24'h000000, 64'h0);
    lit("aligned", 64'h1122334455667788);

    // Unaligned partial write
    cycle(1'b1, 8'h0F, 24'h000004, 64'hAABBCCDDEEFF0011);
    cycle(1'b1, 8'h00, 24'h000004, 64'h0);
    lit("unaligned_lo", 64'h00000000EEFF0011, 8'h0F);
    cycle(1'b1, 8'h00, 24'h000000, 64'h0);
    lit("addr0_after_partial", 64'hEEFF001155667788);

    // Full write at 8, overlapping read at 2
    cycle(1'b1, 8'hFF, 24'h000008, 64'h2233445566778899);
    cycle(1'b1, 8'h00, 24'h000008, 64'h0);
    lit("addr8", 64'h2233445566778899);
    cycle(1'b1, 8'h00, 24'h000002, 64'h0);
    lit("overlap_addr2", 64'h8899EEFF00115566);

    // Disabled cycle: output holds, memory untouched
    cycle(1'b0, 8'hFF, 24'h000000, 64'h0F0F0F0F0F0F0F0F);
    lit("en0_hold", 64'h8899EEFF00115566);
    cycle(1'b1, 8'h00, 24'h000000, 64'h0);
    lit("en0_mem_kept", 64'hEEFF001155667788);

    // Read-first
    cycle(1'b1, 8'hFF, 24'h000010, 64'h0102030405060708);
    cycle(1'b1, 8'hFF, 24'h000010, 64'hDEADBEEFCAFEF00D);
    lit("read_first_old", 64'h0102030405060708);
    cycle(1'b1, 8'h00, 24'h000010, 64'h0);
    lit("read_first_new", 64'hDEADBEEFCAFEF00D);

    // Mid-sequence reset keeps memory
    async_reset();
    cycle(1'b1, 8'h00, 24'h000000, 64'h0);
    lit("after_reset", 64'hEEFF001155667788);

    // Wrap past the top of memory; upper address bits ignored on the read back
    cycle(1'b1, 8'hFF, 24'h000FFD, 64'h0807060504030201);
    cycle(1'b1, 8'h00, 24'hAB0FFD, 64'h0);
    lit("wrap_read", 64'h0807060504030201);
    cycle(1'b1, 8'h00, 24'h000000, 64'h0);
    lit("wrap_low_bytes", 64'hEEFF000807060504);

    // Randomised traffic, concentrated near 0 and the top so windows overlap
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset();
      end else begin
        sel = $urandom_range(0, 2);
        addr = 24'($urandom);
        if (sel == 0) addr[MEM_AW-1:0] = 12'($urandom_range(0, 47));
        else if (sel == 1) addr[MEM_AW-1:0] = 12'($urandom_range(DEPTH - 48, DEPTH - 1));
        cycle($urandom_range(0, 9) != 0, 8'($urandom), addr, {$urandom, $urandom});
      end
    end

    @(negedge clk); #1;
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
